// File: rtl/button_debouncer_pkg.sv
// Shared constants and helpers for the push-button conditioning block.
package button_debouncer_pkg;

    // 10 ms of stability at a 50 MHz system clock.
    localparam int DEBOUNCE_CYCLES_50MHZ = 500000;

    // Short stability window used by simulation benches.
    localparam int DEBOUNCE_CYCLES_SIM = 4;

    // A press is the debounced level leaving the released (idle) level.
    // Active-low keys press on a fall. Active-high keys press on a rise.
    function automatic logic is_press(input logic rise, input logic fall, input logic idle_level);
        return idle_level ? fall : rise;
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button bundle between the board key pins and the button PIO.
// The master drives the raw pins and the capture clear.
// The slave (the debouncer) returns the conditioned level, the edge pulses and the capture flags.
interface button_debouncer_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] btn_raw;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] btn_level;
    logic [WIDTH-1:0] btn_rise;
    logic [WIDTH-1:0] btn_fall;
    logic [WIDTH-1:0] edge_capture;

    modport master (
        output btn_raw,
        output edge_clr,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  edge_capture
    );

    modport slave (
        input  btn_raw,
        input  edge_clr,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output edge_capture
    );
endinterface

// File: rtl/button_debounce_chan.sv
// One button channel: a two-flop synchroniser, a stability counter, a debounced level register
// and one-cycle rise/fall pulses.
module button_debounce_chan
    import button_debouncer_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    // The counter stops here, so it never reaches DEBOUNCE_CYCLES and never wraps.
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             rise_reg;
    logic             fall_reg;

    // Bring the asynchronous pin into the clk domain.
    // The pin reaches the rest of the logic only through these two flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= IDLE_LEVEL;
            sync2_reg <= IDLE_LEVEL;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    // Any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg   <= '0;
            level_reg <= IDLE_LEVEL;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == TERMINAL) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
                rise_reg  <= sync2_reg;
                fall_reg  <= ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/button_debouncer.sv
// Conditions raw push-button pins for the button PIO.
// It has one independent debounce channel per key, plus a sticky, clearable press-capture bit per key.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int   WIDTH           = 2,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input logic               clk,
    input logic               reset,
    button_debouncer_if.slave bus
);

    // A one-cycle window cannot tell a glitch from a change, so reject it when the design is elaborated.
    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
            $error("button_debouncer: DEBOUNCE_CYCLES must be at least 2");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic rise;
            logic fall;
            logic capture_reg;

            button_debounce_chan #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W),
                .IDLE_LEVEL      (IDLE_LEVEL)
            ) u_chan (
                .clk   (clk),
                .reset (reset),
                .raw   (bus.btn_raw[gi]),
                .level (bus.btn_level[gi]),
                .rise  (rise),
                .fall  (fall)
            );

            // Sticky press flag.
            // A press in the same cycle as a clear wins, so the press is not lost.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    capture_reg <= 1'b0;
                end else if (is_press(rise, fall, IDLE_LEVEL)) begin
                    capture_reg <= 1'b1;
                end else if (bus.edge_clr[gi]) begin
                    capture_reg <= 1'b0;
                end
            end

            assign bus.btn_rise[gi]     = rise;
            assign bus.btn_fall[gi]     = fall;
            assign bus.edge_capture[gi] = capture_reg;
        end
    endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (DEBOUNCE_CYCLES=4, IDLE_LEVEL=1).
// A history-window model checks every cycle, and literal expectations pin key cycles.
module tb_button_debouncer;
    import button_debouncer_pkg::*;

    localparam int   W    = 2;
    localparam int   DC   = DEBOUNCE_CYCLES_SIM;
    localparam logic IDLE = 1'b1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    button_debouncer_if #(.WIDTH(W)) bus ();

    button_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC),
        .IDLE_LEVEL      (IDLE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // hist[k] holds the pin vector sampled k edges ago.
    // A channel flips when the DC samples seen through the two-edge sync delay all oppose the
    // current level, and at least DC edges have passed since the last flip or reset.
    logic [W-1:0] hist [DC+2];
    int           age  [W];
    logic [W-1:0] m_level, m_rise, m_fall, m_cap;

    task automatic model_reset();
        for (int k = 0; k < DC + 2; k++) hist[k] = {W{IDLE}};
        for (int c = 0; c < W; c++) age[c] = 0;
        m_level = {W{IDLE}};
        m_rise  = '0;
        m_fall  = '0;
        m_cap   = '0;
    endtask

    task automatic model_step();
        logic all_opp;
        if (reset) begin
            model_reset();
            return;
        end
        for (int c = 0; c < W; c++) begin
            if (m_fall[c]) m_cap[c] = 1'b1;
            else if (bus.edge_clr[c]) m_cap[c] = 1'b0;
        end
        for (int k = DC + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = bus.btn_raw;
        for (int c = 0; c < W; c++) begin
            if (age[c] < DC) age[c]++;
            all_opp = 1'b1;
            for (int k = 2; k <= DC + 1; k++)
                if (hist[k][c] == m_level[c]) all_opp = 1'b0;
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            if (all_opp && age[c] >= DC) begin
                m_level[c] = ~m_level[c];
                m_rise[c]  = m_level[c];
                m_fall[c]  = ~m_level[c];
                age[c]     = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("model_level",   bus.btn_level,    m_level);
            check("model_rise",    bus.btn_rise,     m_rise);
            check("model_fall",    bus.btn_fall,     m_fall);
            check("model_capture", bus.edge_capture, m_cap);
        end
    end

    // Advance n falling edges, then drive just after the edge.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        bus.btn_raw  = 2'b00;
        bus.edge_clr = 2'b00;
        #1 reset = 1'b1;
        #1;
        check("reset_level", bus.btn_level, 2'b11);
        check("reset_rise", bus.btn_rise, 2'b00);
        check("reset_fall", bus.btn_fall, 2'b00);
        check("reset_capture", bus.edge_capture, 2'b00);
        cycles(3);
        reset = 1'b0;
        cycles(2);
        bus.btn_raw = 2'b11;
        cycles(8);
        check("post_reset_level", bus.btn_level, 2'b11);

        // Clean press on channel 0
        bus.btn_raw[0] = 1'b0;
        cycles(5);
        check("press_edge5_level", bus.btn_level, 2'b11);
        cycles(1);
        check("press_edge6_level", bus.btn_level, 2'b10);
        check("press_edge6_fall", bus.btn_fall, 2'b01);
        check("press_edge6_capture", bus.edge_capture, 2'b00);
        cycles(1);
        check("press_edge7_fall", bus.btn_fall, 2'b00);
        check("press_edge7_capture", bus.edge_capture, 2'b01);
        bus.btn_raw[0] = 1'b1;
        cycles(5);
        check("release_edge5_level", bus.btn_level, 2'b10);
        cycles(1);
        check("release_edge6_level", bus.btn_level, 2'b11);
        check("release_edge6_rise", bus.btn_rise, 2'b01);
        cycles(1);
        check("release_edge7_rise", bus.btn_rise, 2'b00);
        check("release_capture", bus.edge_capture, 2'b01);
        cycles(2);

        // Bounce on channel 1
        for (int i = 0; i < 10; i++) begin
            bus.btn_raw[1] = 1'b0;
            cycles(3);
            bus.btn_raw[1] = 1'b1;
            cycles(1);
        end
        check("bounce_level", bus.btn_level, 2'b11);
        check("bounce_capture", bus.edge_capture, 2'b01);
        bus.btn_raw[1] = 1'b0;
        cycles(5);
        check("hold_edge5_level", bus.btn_level, 2'b11);
        cycles(1);
        check("hold_edge6_level", bus.btn_level, 2'b01);
        check("hold_edge6_fall", bus.btn_fall, 2'b10);
        cycles(1);
        check("hold_capture", bus.edge_capture, 2'b11);
        bus.btn_raw[1] = 1'b1;
        cycles(8);

        // Per-channel clear, then clear colliding with a new press
        bus.edge_clr = 2'b10;
        cycles(1);
        check("clr1_only", bus.edge_capture, 2'b01);
        bus.edge_clr = 2'b01;
        cycles(1);
        check("clr0", bus.edge_capture, 2'b00);
        bus.edge_clr = 2'b00;
        bus.btn_raw[0] = 1'b0;
        cycles(6);
        check("setclr_fall", bus.btn_fall, 2'b01);
        bus.edge_clr = 2'b01;
        cycles(1);
        bus.edge_clr = 2'b00;
        check("set_beats_clr", bus.edge_capture, 2'b01);
        bus.btn_raw[0] = 1'b1;
        cycles(8);
        bus.edge_clr = 2'b11;
        cycles(1);
        bus.edge_clr = 2'b00;

        // Reset in the middle of a count
        bus.btn_raw[0] = 1'b0;
        cycles(3);
        reset = 1'b1;
        #1;
        check("midreset_level", bus.btn_level, 2'b11);
        check("midreset_capture", bus.edge_capture, 2'b00);
        cycles(2);
        reset = 1'b0;
        cycles(5);
        check("after_reset_edge5_level", bus.btn_level, 2'b11);
        cycles(1);
        check("after_reset_edge6_level", bus.btn_level, 2'b10);
        check("after_reset_edge6_fall", bus.btn_fall, 2'b01);
        bus.btn_raw[0] = 1'b1;
        cycles(8);
        bus.edge_clr = 2'b11;
        cycles(1);
        bus.edge_clr = 2'b00;

        // Channel independence: ch0 at t=0, ch1 at t=2
        bus.btn_raw[0] = 1'b0;
        cycles(2);
        bus.btn_raw[1] = 1'b0;
        cycles(4);
        check("indep_edge6_level", bus.btn_level, 2'b10);
        check("indep_edge6_fall", bus.btn_fall, 2'b01);
        cycles(2);
        check("indep_edge8_level", bus.btn_level, 2'b00);
        check("indep_edge8_fall", bus.btn_fall, 2'b10);
        cycles(1);
        check("indep_capture", bus.edge_capture, 2'b11);
        bus.btn_raw = 2'b11;
        cycles(8);
        check("final_level", bus.btn_level, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
